regfile_bypass: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/regfile_bypass_if.sv | 29 ++
 rtl/rf_read_port.sv | 32 +++
 rtl/regfile_bypass.sv | 77 +++++++
 tb/tb_regfile_bypass.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types: data word, register index and
// the register-file hazard-source encoding.
package cpu_types_pkg;
  localparam int RF_NREGS = 32;
  localparam int RF_DW    = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int ZERO_REG = 0;

  typedef logic [RF_DW-1:0] word_t;
  typedef logic [RF_AW-1:0] regbits_t;

  // bit0: read port 1 bypassed, bit1: read port 2 bypassed
  typedef logic [1:0] rf_hazard_t;
endpackage

// File: rtl/regfile_bypass_if.sv
// Register-file bundle: writeback writes,
// decode reads and sees which ports were bypassed.
interface regfile_bypass_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wen;
  logic [AW-1:0] wsel;
  logic [DW-1:0] wdat;
  logic [AW-1:0] rsel_1;
  logic [AW-1:0] rsel_2;
  logic [DW-1:0] rdat_1;
  logic [DW-1:0] rdat_2;
  logic [1:0]    hazard;

  modport rf (
    input  wen, wsel, wdat, rsel_1, rsel_2,
    output rdat_1, rdat_2, hazard
  );

  modport wb (
    output wen, wsel, wdat
  );

  modport dec (
    output rsel_1, rsel_2,
    input  rdat_1, rdat_2, hazard
  );
endinterface

// File: rtl/rf_read_port.sv
// One register-file read port: array select,
// same-cycle write bypass and zero-register mask.
module rf_read_port #(
  parameter int NREGS    = 32,
  parameter int DW       = 32,
  parameter int ZERO_REG = 0,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][DW-1:0] regs,
  input  logic                     wen,
  input  logic [AW-1:0]            wsel,
  input  logic [DW-1:0]            wdat,
  input  logic [AW-1:0]            rsel,
  output logic [DW-1:0]            rdat,
  output logic                     hit
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic is_zero;

  assign is_zero = (rsel == ZR);
  assign hit     = wen && (rsel == wsel) && (wsel != ZR);

  always_comb begin
    rdat = regs[rsel];
    unique case (1'b1)
      is_zero: rdat = '0;
      hit:     rdat = wdat;
      default: rdat = regs[rsel];
    endcase
  end
endmodule

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file with internal
// read-after-write bypass for the in-flight write.
module regfile_bypass
  import cpu_types_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int DW       = RF_DW,
  parameter int ZERO_REG = cpu_types_pkg::ZERO_REG,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          WEN,
  input  logic [AW-1:0] wsel,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] rsel_1,
  input  logic [AW-1:0] rsel_2,
  output logic [DW-1:0] rdat_1,
  output logic [DW-1:0] rdat_2,
  output rf_hazard_t    rf_hazard_src
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  regfile_bypass_if #(.AW(AW), .DW(DW)) rf_bus ();

  logic [NREGS-1:0][DW-1:0] regs;
  logic                     wen_live;
  logic                     hit_1;
  logic                     hit_2;

  assign rf_bus.wen    = WEN;
  assign rf_bus.wsel   = wsel;
  assign rf_bus.wdat   = wdat;
  assign rf_bus.rsel_1 = rsel_1;
  assign rf_bus.rsel_2 = rsel_2;

  // Reset masks the write so nothing is bypassed or stored.
  assign wen_live = rf_bus.wen && nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs <= '0;
    end else if (rf_bus.wen && rf_bus.wsel != ZR) begin
      regs[rf_bus.wsel] <= rf_bus.wdat;
    end
  end

  rf_read_port #(
    .NREGS(NREGS), .DW(DW), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_port_1 (
    .regs (regs),
    .wen  (wen_live),
    .wsel (rf_bus.wsel),
    .wdat (rf_bus.wdat),
    .rsel (rf_bus.rsel_1),
    .rdat (rf_bus.rdat_1),
    .hit  (hit_1)
  );

  rf_read_port #(
    .NREGS(NREGS), .DW(DW), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_port_2 (
    .regs (regs),
    .wen  (wen_live),
    .wsel (rf_bus.wsel),
    .wdat (rf_bus.wdat),
    .rsel (rf_bus.rsel_2),
    .rdat (rf_bus.rdat_2),
    .hit  (hit_2)
  );

  assign rf_bus.hazard = {hit_2, hit_1};

  assign rdat_1        = rf_bus.rdat_1;
  assign rdat_2        = rf_bus.rdat_2;
  assign rf_hazard_src = rf_bus.hazard;
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: reset, write,
// bypass, zero register, async reset, overwrite.
module tb_regfile_bypass;
  logic        CLK;
  logic        nRST;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel_1;
  logic [4:0]  rsel_2;
  logic [31:0] rdat_1;
  logic [31:0] rdat_2;
  logic [1:0]  rf_hazard_src;

  int checks = 0;
  int errors = 0;

  regfile_bypass dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .WEN           (WEN),
    .wsel          (wsel),
    .wdat          (wdat),
    .rsel_1        (rsel_1),
    .rsel_2        (rsel_2),
    .rdat_1        (rdat_1),
    .rdat_2        (rdat_2),
    .rf_hazard_src (rf_hazard_src)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    nRST   = 1'b0;
    WEN    = 1'b1;
    wsel   = 5'd5;
    wdat   = 32'hDEAD_BEEF;
    rsel_1 = 5'd5;
    rsel_2 = 5'd0;

    // 1: reset holds everything at zero
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_rdat1", rdat_1, 32'h0);
      chk("rst_haz", {30'b0, rf_hazard_src}, 32'h0);
    end
    WEN  = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_after", rdat_1, 32'h0);

    // 2: basic write then read
    WEN  = 1'b1;
    wsel = 5'd8;
    wdat = 32'h0000_1234;
    @(negedge CLK);
    WEN    = 1'b0;
    rsel_1 = 5'd8;
    rsel_2 = 5'd9;
    #1;
    chk("wr_rd1", rdat_1, 32'h1234);
    chk("wr_rd2", rdat_2, 32'h0);
    chk("wr_haz", {30'b0, rf_hazard_src}, 32'h0);

    // 3: same-cycle bypass
    @(negedge CLK);
    WEN    = 1'b1;
    wsel   = 5'd3;
    wdat   = 32'hCAFE_F00D;
    rsel_1 = 5'd3;
    rsel_2 = 5'd4;
    #1;
    chk("byp1_dat", rdat_1, 32'hCAFE_F00D);
    chk("byp1_haz", {30'b0, rf_hazard_src}, 32'h1);
    rsel_1 = 5'd4;
    rsel_2 = 5'd3;
    #1;
    chk("byp2_dat", rdat_2, 32'hCAFE_F00D);
    chk("byp2_haz", {30'b0, rf_hazard_src}, 32'h2);
    rsel_1 = 5'd3;
    #1;
    chk("byp3_d1", rdat_1, 32'hCAFE_F00D);
    chk("byp3_d2", rdat_2, 32'hCAFE_F00D);
    chk("byp3_haz", {30'b0, rf_hazard_src}, 32'h3);
    @(negedge CLK);
    WEN = 1'b0;
    #1;
    chk("byp_arr", rdat_1, 32'hCAFE_F00D);
    chk("byp_arr_haz", {30'b0, rf_hazard_src}, 32'h0);

    // 4: zero register
    @(negedge CLK);
    WEN    = 1'b1;
    wsel   = 5'd0;
    wdat   = 32'hFFFF_FFFF;
    rsel_1 = 5'd0;
    rsel_2 = 5'd0;
    #1;
    chk("z_d1", rdat_1, 32'h0);
    chk("z_d2", rdat_2, 32'h0);
    chk("z_haz", {30'b0, rf_hazard_src}, 32'h0);
    @(negedge CLK);
    WEN = 1'b0;
    #1;
    chk("z_post_d1", rdat_1, 32'h0);
    chk("z_post_d2", rdat_2, 32'h0);

    // 5: fill, then async reset between edges
    @(negedge CLK);
    for (int i = 1; i < 32; i++) begin
      WEN  = 1'b1;
      wsel = 5'(i);
      wdat = 32'(i);
      @(negedge CLK);
    end
    WEN    = 1'b0;
    rsel_1 = 5'd31;
    rsel_2 = 5'd8;
    #1;
    chk("fill_31", rdat_1, 32'd31);
    chk("fill_8", rdat_2, 32'd8);
    nRST = 1'b0;
    WEN  = 1'b1;
    wsel = 5'd31;
    wdat = 32'h5555_AAAA;
    #1;
    chk("arst_d1", rdat_1, 32'h0);
    chk("arst_d2", rdat_2, 32'h0);
    chk("arst_haz", {30'b0, rf_hazard_src}, 32'h0);
    WEN  = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    WEN  = 1'b1;
    wsel = 5'd7;
    wdat = 32'd7;
    @(negedge CLK);
    WEN = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsel_1 = 5'(i);
      #1;
      chk($sformatf("post_rst_r%0d", i), rdat_1,
          (i == 7) ? 32'd7 : 32'd0);
    end

    // 6: back-to-back overwrite through bypass
    @(negedge CLK);
    rsel_1 = 5'd10;
    WEN    = 1'b1;
    wsel   = 5'd10;
    for (int v = 1; v <= 3; v++) begin
      wdat = 32'(v);
      #1;
      chk($sformatf("ow_dat%0d", v), rdat_1, 32'(v));
      chk($sformatf("ow_haz%0d", v),
          {30'b0, rf_hazard_src}, 32'h1);
      @(negedge CLK);
    end
    WEN = 1'b0;
    #1;
    chk("ow_hold", rdat_1, 32'd3);
    chk("ow_hold_haz", {30'b0, rf_hazard_src}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
